// File: rtl/serdes_pkg.sv
// Shared types and constants for the serial frame transmitter.
// SERDES_TX_PARITY_EN adds the PARITY state to the FSM encoding.
package serdes_pkg;

    localparam int FRAME_BITS   = 8;
    localparam int IDLE_GAP_MAX = 15;

`ifdef SERDES_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_PARITY, S_GAP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_GAP} state_t;
`endif

endpackage

// File: rtl/serdes_hold_reg.sv
// One-entry hold register between the byte-pair handshake and the shifter.
// A write and a read never coincide because the writer is stalled while full.
module serdes_hold_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= 1'b0;
            data_out <= '0;
        end else if (wr_en) begin
            full     <= 1'b1;
            data_out <= data_in;
        end else if (rd_en) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/serdes_frame_tx.sv
// Serialises A/B byte pairs as frames: start pulse, 8 bits MSB first, optional
// parity cycle (SERDES_TX_PARITY_EN), then IDLE_GAP idle cycles.
//
// state    | meaning
// S_IDLE   | no frame in flight, waiting for the hold register to fill
// S_START  | one-cycle start pulse, data lines low
// S_SHIFT  | bits 7..0 of A and B on the serial lines
// S_PARITY | XOR of A and of B (only with SERDES_TX_PARITY_EN)
// S_GAP    | IDLE_GAP quiet cycles before the next frame
module serdes_frame_tx #(
    parameter int IDLE_GAP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic       start_o,
    output logic       a_bit_o,
    output logic       b_bit_o,
    output logic       busy,
    output logic       frame_done
);
    import serdes_pkg::*;

    localparam int GAP_EFF = (IDLE_GAP > IDLE_GAP_MAX) ? IDLE_GAP_MAX : IDLE_GAP;
    localparam logic [3:0] GAP_LOAD = 4'(GAP_EFF - 1);
`ifdef SERDES_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    state_t      state;
    logic [7:0]  sh_a, sh_b;
    logic [2:0]  bit_cnt;
    logic [3:0]  gap_cnt;
    logic        hold_full;
    logic [15:0] hold_data;
    logic        take, launch, frame_end, gap_end;

    assign in_ready = ~hold_full;
    assign take     = in_valid & ~hold_full;

`ifdef SERDES_TX_PARITY_EN
    assign frame_end = (state == S_PARITY);
`else
    assign frame_end = (state == S_SHIFT) && (bit_cnt == 3'd0);
`endif
    assign gap_end = (state == S_GAP) && (gap_cnt == 4'd0);

    // A held pair starts a frame from IDLE, at the end of the gap, or straight
    // after the final bit when there is no gap, so back-to-back frames abut.
    assign launch = hold_full && ((state == S_IDLE) || gap_end ||
                                  (frame_end && (GAP_EFF == 0)));

    serdes_hold_reg #(.WIDTH(16)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (take),
        .rd_en    (launch),
        .data_in  ({in_a, in_b}),
        .data_out (hold_data),
        .full     (hold_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            sh_a       <= '0;
            sh_b       <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            start_o    <= 1'b0;
            a_bit_o    <= 1'b0;
            b_bit_o    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            start_o    <= 1'b0;
            a_bit_o    <= 1'b0;
            b_bit_o    <= 1'b0;
            frame_done <= 1'b0;
            if (launch) begin
                state   <= S_START;
                sh_a    <= hold_data[15:8];
                sh_b    <= hold_data[7:0];
                start_o <= 1'b1;
                busy    <= 1'b1;
            end else if (frame_end) begin
                if (GAP_EFF != 0) begin
                    state   <= S_GAP;
                    gap_cnt <= GAP_LOAD;
                end else begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    S_START: begin
                        state   <= S_SHIFT;
                        bit_cnt <= 3'(FRAME_BITS - 1);
                        a_bit_o <= sh_a[FRAME_BITS-1];
                        b_bit_o <= sh_b[FRAME_BITS-1];
                    end
                    S_SHIFT: begin
                        if (bit_cnt != 3'd0) begin
                            bit_cnt    <= bit_cnt - 3'd1;
                            a_bit_o    <= sh_a[bit_cnt - 3'd1];
                            b_bit_o    <= sh_b[bit_cnt - 3'd1];
                            frame_done <= (bit_cnt == 3'd1) && !PARITY_EN;
                        end
`ifdef SERDES_TX_PARITY_EN
                        else begin
                            state      <= S_PARITY;
                            a_bit_o    <= ^sh_a;
                            b_bit_o    <= ^sh_b;
                            frame_done <= 1'b1;
                        end
`endif
                    end
                    S_GAP: begin
                        if (gap_cnt == 4'd0) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serdes_frame_tx.sv
// Directed bench for serdes_frame_tx: a scoreboard follows every frame of the
// IDLE_GAP=0 instance; a second instance with IDLE_GAP=3 covers the gap.
module tb_serdes_frame_tx;

`ifdef SERDES_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int LAST = PAR ? 8 : 7;
    localparam int PERIOD0 = 1 + 8 + (PAR ? 1 : 0);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v0 = 1'b0, rdy0, st0, ab0, bb0, busy0, fd0;
    logic [7:0] a0 = '0, b0 = '0;
    logic       v3 = 1'b0, rdy3, st3, ab3, bb3, busy3, fd3;
    logic [7:0] a3 = '0, b3 = '0;

    serdes_frame_tx #(.IDLE_GAP(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_a(a0), .in_b(b0),
        .start_o(st0), .a_bit_o(ab0), .b_bit_o(bb0), .busy(busy0), .frame_done(fd0)
    );

    serdes_frame_tx #(.IDLE_GAP(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_a(a3), .in_b(b3),
        .start_o(st3), .a_bit_o(ab3), .b_bit_o(bb3), .busy(busy3), .frame_done(fd3)
    );

    int checks = 0;
    int errors = 0;
    int acc    = 0;
    int frames = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transfers are recorded just before the edge that performs them.
    task automatic cyc();
        if (!rst && v0 && rdy0) begin
            exp_q.push_back({a0, b0});
            acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle0(input string tag);
        int n = 0;
        while (busy0 && n < 80) begin
            cyc();
            n++;
        end
        chk(tag, busy0, 1'b0);
    endtask

    int bidx = -1;
    logic [15:0] cur = '0;
    always @(negedge clk) begin
        if (rst) begin
            bidx = -1;
            exp_q.delete();
        end else if (bidx >= 0) begin
            chk("mon_start_in_frame", st0, 1'b0);
            if (bidx < 8) begin
                chk("mon_a_bit", ab0, cur[15 - bidx]);
                chk("mon_b_bit", bb0, cur[7 - bidx]);
            end else begin
                chk("mon_a_parity", ab0, ^cur[15:8]);
                chk("mon_b_parity", bb0, ^cur[7:0]);
            end
            chk("mon_frame_done", fd0, bidx == LAST);
            if (bidx == LAST) begin
                bidx = -1;
                frames++;
            end else begin
                bidx++;
            end
        end else begin
            chk("mon_idle_a", ab0, 1'b0);
            chk("mon_idle_b", bb0, 1'b0);
            chk("mon_idle_done", fd0, 1'b0);
            if (st0) begin
                chk("mon_frame_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    cur  = exp_q.pop_front();
                    bidx = 0;
                end
            end
        end
    end

    initial begin
        int n;
        int acc_start, frames_start, exp_acc;

        // reset values
        cyc();
        cyc();
        chk("rst_ready", rdy0, 1'b1);
        chk("rst_start", st0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", fd0, 1'b0);
        chk("rst_bits", {ab0, bb0}, 2'b00);
        chk("rst_ready3", rdy3, 1'b1);
        chk("rst_busy3", busy3, 1'b0);
        rst = 1'b0;
        cyc();

        // single frame A=0x02 B=0x03
        v0 = 1'b1; a0 = 8'h02; b0 = 8'h03;
        cyc();
        v0 = 1'b0;
        chk("single_ready_full", rdy0, 1'b0);
        chk("single_busy_e0", busy0, 1'b0);
        cyc();
        chk("single_start", st0, 1'b1);
        chk("single_busy", busy0, 1'b1);
        chk("single_ready_drained", rdy0, 1'b1);
        chk("single_start_a", ab0, 1'b0);
        cyc();
        chk("single_msb_a", ab0, 1'b0);
        wait_idle0("single_idle_timeout");
        chk("single_frames", frames, 1);

        // back-to-back, no gap
        v0 = 1'b1; a0 = 8'hC3; b0 = 8'h5A;
        cyc();
        a0 = 8'hFF; b0 = 8'h00;
        chk("b2b_ready_e0", rdy0, 1'b0);
        cyc();
        cyc();
        v0 = 1'b0;
        n = 0;
        while (!fd0 && n < 30) begin
            chk("b2b_ready_held", rdy0, 1'b0);
            cyc();
            n++;
        end
        chk("b2b_first_done", fd0, 1'b1);
        cyc();
        chk("b2b_second_start", st0, 1'b1);
        chk("b2b_busy_kept", busy0, 1'b1);
        wait_idle0("b2b_idle_timeout");
        chk("b2b_frames", frames, 3);

        // two queued frames through the IDLE_GAP=3 instance
        v3 = 1'b1; a3 = 8'h81; b3 = 8'h18;
        cyc();
        a3 = 8'h7E; b3 = 8'hE7;
        cyc();
        cyc();
        v3 = 1'b0;
        n = 0;
        while (!fd3 && n < 30) begin
            cyc();
            n++;
        end
        chk("gap_first_done", fd3, 1'b1);
        for (int g = 0; g < 3; g++) begin
            cyc();
            chk("gap_outputs", {st3, ab3, bb3, fd3}, 4'b0000);
            chk("gap_busy", busy3, 1'b1);
        end
        cyc();
        chk("gap_second_start", st3, 1'b1);
        n = 0;
        while (busy3 && n < 40) begin
            cyc();
            n++;
        end
        chk("gap_idle_timeout", busy3, 1'b0);

        // backpressure: transfers at edges 0, 2, 2+P, 2+2P, ...
        acc_start    = acc;
        frames_start = frames;
        exp_acc      = 2 + (30 - 3) / PERIOD0;
        for (int i = 0; i < 30; i++) begin
            v0 = 1'b1;
            a0 = 8'(i * 7 + 1);
            b0 = 8'(i * 13 + 5);
            cyc();
        end
        v0 = 1'b0;
        chk("bp_accepted", acc - acc_start, exp_acc);
        wait_idle0("bp_idle_timeout");
        chk("bp_queue_drained", exp_q.size(), 0);
        chk("bp_frames", frames - frames_start, acc - acc_start);

`ifdef SERDES_TX_PARITY_EN
        // parity frame A=0x07 B=0x03
        v0 = 1'b1; a0 = 8'h07; b0 = 8'h03;
        cyc();
        v0 = 1'b0;
        for (int k = 0; k < 10; k++) cyc();
        chk("par_a", ab0, 1'b1);
        chk("par_b", bb0, 1'b0);
        chk("par_done", fd0, 1'b1);
        wait_idle0("par_idle_timeout");
`endif

        // reset at bit 4 with a second pair held
        frames_start = frames;
        v0 = 1'b1; a0 = 8'hA5; b0 = 8'h5A;
        cyc();
        a0 = 8'h11; b0 = 8'h22;
        cyc();
        cyc();
        v0 = 1'b0;
        chk("rstmid_held", rdy0, 1'b0);
        cyc();
        cyc();
        cyc();
        chk("rstmid_bit4_a", ab0, 1'b0);
        chk("rstmid_bit4_b", bb0, 1'b1);
        rst = 1'b1;
        cyc();
        chk("rstmid_outputs", {st0, ab0, bb0, fd0, busy0}, 5'b00000);
        chk("rstmid_ready", rdy0, 1'b1);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            chk("rstmid_quiet", {st0, fd0, busy0}, 3'b000);
        end
        chk("rstmid_frames", frames, frames_start);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
